// File: rtl/ppi_lane_merger.sv
// ppi_lane_merger
//   Receive-side lane merger and DSI packet parser. Each cycle the byte group
//   on the active PPI lanes is pushed into a byte FIFO in lane order. The FIFO
//   drains one byte per cycle into a parser that splits each packet into a
//   4-byte header, an optional payload and a CRC-16 footer.
//
// Ports
//   dsi_clk, dsi_rst_n           clock, asynchronous active-low reset
//   active_lanes[1:0]            lane count minus one
//   ppi_data_lane0..3[7:0]       lane bytes
//   ppi_lane0..3_en              lane enables (lane0_en qualifies a group)
//   rx_byte/rx_valid/rx_ready    payload byte stream with handshake
//   rx_sop/rx_eop                first / last payload byte markers
//   hdr_di[7:0], hdr_wc[15:0]    header fields of the current/last packet
//   pkt_done, pkt_long, crc_err  per-packet completion pulse and status
//   lane_err, ovf_err            sticky error flags
module ppi_lane_merger #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
    input  logic        dsi_clk,
    input  logic        dsi_rst_n,
    input  logic [1:0]  active_lanes,
    input  logic [7:0]  ppi_data_lane0,
    input  logic [7:0]  ppi_data_lane1,
    input  logic [7:0]  ppi_data_lane2,
    input  logic [7:0]  ppi_data_lane3,
    input  logic        ppi_lane0_en,
    input  logic        ppi_lane1_en,
    input  logic        ppi_lane2_en,
    input  logic        ppi_lane3_en,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic [7:0]  hdr_di,
    output logic [15:0] hdr_wc,
    output logic        pkt_done,
    output logic        pkt_long,
    output logic        crc_err,
    output logic        lane_err,
    output logic        ovf_err
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_HDR, S_PAY, S_CRC_LO, S_CRC_HI} state_t;

    // CRC-16/CCITT, reflected (poly 0x8408), data bits consumed LSB first
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic is_long(input logic [7:0] di);
        case (di[5:0])
            6'h09, 6'h19, 6'h29, 6'h39, 6'h0E, 6'h1E, 6'h2E, 6'h3E: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    lanes_q, lanes_eff;
    logic [2:0]    grp_n;
    logic [3:0]    lane_en;
    logic [7:0]    lane_data [4];
    logic          lane_miss, fifo_empty, push_ok, vld_p0;
    logic [AW:0]   room;
    logic [7:0]    pop_byte_p0;

    state_t        state;
    logic [1:0]    hdr_idx;
    logic [7:0]    di_q, footer_lo;
    logic [15:0]   wc_q, pay_cnt, crc_q;

    assign lane_en      = {ppi_lane3_en, ppi_lane2_en, ppi_lane1_en, ppi_lane0_en};
    assign lane_data[0] = ppi_data_lane0;
    assign lane_data[1] = ppi_data_lane1;
    assign lane_data[2] = ppi_data_lane2;
    assign lane_data[3] = ppi_data_lane3;
    assign fifo_empty   = (count == '0);

    // The lane count may only change between packets with nothing buffered,
    // so a byte group never straddles two different lane widths.
    assign lanes_eff   = (fifo_empty && state == S_HDR) ? active_lanes : lanes_q;
    assign grp_n       = {1'b0, lanes_eff} + 3'd1;
    assign vld_p0      = !fifo_empty && (state != S_PAY || rx_ready);
    assign pop_byte_p0 = mem[rd_ptr];
    // A same-cycle pop frees one entry for the incoming group.
    assign room        = DEPTH_C - count + (AW+1)'(vld_p0);
    assign push_ok     = ppi_lane0_en && ((AW+1)'(grp_n) <= room);

    always_comb begin
        lane_miss = 1'b0;
        for (int k = 1; k < 4; k++) begin
            if (k <= int'(lanes_eff) && !lane_en[k]) lane_miss = 1'b1;
        end
    end

    // ---- Write stage: lane group into FIFO storage ----
    always_ff @(posedge dsi_clk) begin
        if (push_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(grp_n)) mem[wr_ptr + AW'(i)] <= lane_data[i];
            end
        end
    end

    always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
        if (!dsi_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            lanes_q  <= 2'd0;
            lane_err <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            lanes_q <= lanes_eff;
            if (push_ok) wr_ptr <= wr_ptr + AW'(grp_n);
            if (vld_p0)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (push_ok ? (AW+1)'(grp_n) : '0) - (AW+1)'(vld_p0);
            if (ppi_lane0_en && lane_miss) lane_err <= 1'b1;
            if (ppi_lane0_en && !push_ok)  ovf_err  <= 1'b1;
        end
    end

    // ---- Parse stage: popped byte into header/payload/footer registers ----
    always_ff @(posedge dsi_clk) begin
        if (vld_p0) begin
            if (state == S_HDR) begin
                case (hdr_idx)
                    2'd0:    di_q       <= pop_byte_p0;
                    2'd1:    wc_q[7:0]  <= pop_byte_p0;
                    2'd2:    wc_q[15:8] <= pop_byte_p0;
                    default: ;  // ECC byte: consumed, not checked
                endcase
            end
            if (state == S_CRC_LO) footer_lo <= pop_byte_p0;
        end
    end

    always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
        if (!dsi_rst_n) begin
            state    <= S_HDR;
            hdr_idx  <= 2'd0;
            pay_cnt  <= 16'd0;
            crc_q    <= CRC_INIT;
            rx_byte  <= 8'd0;
            rx_valid <= 1'b0;
            rx_sop   <= 1'b0;
            rx_eop   <= 1'b0;
            hdr_di   <= 8'd0;
            hdr_wc   <= 16'd0;
            pkt_done <= 1'b0;
            pkt_long <= 1'b0;
            crc_err  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;

            // Output slot: refilled by a payload pop, emptied by acceptance
            if (vld_p0 && state == S_PAY) begin
                rx_byte  <= pop_byte_p0;
                rx_valid <= 1'b1;
                rx_sop   <= (pay_cnt == hdr_wc);
                rx_eop   <= (pay_cnt == 16'd1);
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
                rx_sop   <= 1'b0;
                rx_eop   <= 1'b0;
            end

            if (vld_p0) begin
                case (state)
                    S_HDR: begin
                        hdr_idx <= hdr_idx + 2'd1;
                        if (hdr_idx == 2'd3) begin
                            hdr_di <= di_q;
                            if (!is_long(di_q)) begin
                                hdr_wc   <= 16'd0;
                                pkt_done <= 1'b1;
                                pkt_long <= 1'b0;
                                crc_err  <= 1'b0;
                            end else begin
                                hdr_wc  <= wc_q;
                                pay_cnt <= wc_q;
                                state   <= (wc_q == 16'd0) ? S_CRC_LO : S_PAY;
                            end
                        end
                    end
                    S_PAY: begin
                        crc_q   <= crc16_upd(crc_q, pop_byte_p0);
                        pay_cnt <= pay_cnt - 16'd1;
                        if (pay_cnt == 16'd1) state <= S_CRC_LO;
                    end
                    S_CRC_LO: state <= S_CRC_HI;
                    default: begin
                        pkt_done <= 1'b1;
                        pkt_long <= 1'b1;
                        crc_err  <= ({pop_byte_p0, footer_lo} != crc_q);
                        crc_q    <= CRC_INIT;
                        state    <= S_HDR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppi_lane_merger.sv
module tb_ppi_lane_merger;

    logic        dsi_clk = 1'b0;
    logic        dsi_rst_n = 1'b0;
    logic [1:0]  active_lanes = 2'd0;
    logic [7:0]  ppi_data_lane0 = 8'd0, ppi_data_lane1 = 8'd0;
    logic [7:0]  ppi_data_lane2 = 8'd0, ppi_data_lane3 = 8'd0;
    logic        ppi_lane0_en = 1'b0, ppi_lane1_en = 1'b0;
    logic        ppi_lane2_en = 1'b0, ppi_lane3_en = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_byte, hdr_di;
    logic [15:0] hdr_wc;
    logic        rx_valid, rx_sop, rx_eop, pkt_done, pkt_long, crc_err, lane_err, ovf_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 dsi_clk = ~dsi_clk;

    ppi_lane_merger #(.FIFO_DEPTH(16), .CRC_INIT(16'hFFFF)) dut (
        .dsi_clk(dsi_clk), .dsi_rst_n(dsi_rst_n), .active_lanes(active_lanes),
        .ppi_data_lane0(ppi_data_lane0), .ppi_data_lane1(ppi_data_lane1),
        .ppi_data_lane2(ppi_data_lane2), .ppi_data_lane3(ppi_data_lane3),
        .ppi_lane0_en(ppi_lane0_en), .ppi_lane1_en(ppi_lane1_en),
        .ppi_lane2_en(ppi_lane2_en), .ppi_lane3_en(ppi_lane3_en),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .hdr_di(hdr_di), .hdr_wc(hdr_wc),
        .pkt_done(pkt_done), .pkt_long(pkt_long), .crc_err(crc_err),
        .lane_err(lane_err), .ovf_err(ovf_err)
    );

    // Observation of accepted payload bytes and packet completions
    int         cyc = 0;
    logic [7:0] acc_byte [256];
    logic       acc_sop  [256];
    logic       acc_eop  [256];
    int         acc_cyc  [256];
    int         acc_n = 0, done_n = 0, valid_n = 0;
    logic       last_long = 1'b0, last_crc = 1'b0;

    always @(posedge dsi_clk) cyc <= cyc + 1;

    always @(negedge dsi_clk) begin
        if (dsi_rst_n) begin
            if (rx_valid) valid_n++;
            if (rx_valid && rx_ready && acc_n < 256) begin
                acc_byte[acc_n] = rx_byte;
                acc_sop[acc_n]  = rx_sop;
                acc_eop[acc_n]  = rx_eop;
                acc_cyc[acc_n]  = cyc;
                acc_n++;
            end
            if (pkt_done) begin
                done_n++;
                last_long = pkt_long;
                last_crc  = crc_err;
            end
        end
    end

    task automatic push(input logic [7:0] b0, b1, b2, b3, input logic [3:0] en);
        ppi_data_lane0 = b0; ppi_data_lane1 = b1;
        ppi_data_lane2 = b2; ppi_data_lane3 = b3;
        {ppi_lane3_en, ppi_lane2_en, ppi_lane1_en, ppi_lane0_en} = en;
        @(posedge dsi_clk); #1;
        {ppi_lane3_en, ppi_lane2_en, ppi_lane1_en, ppi_lane0_en} = 4'b0000;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge dsi_clk);
        #1;
    endtask

    task automatic do_reset;
        dsi_rst_n = 1'b0;
        repeat (2) @(posedge dsi_clk);
        #1 dsi_rst_n = 1'b1;
        wait_cycles(1);
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++; if (rx_valid !== 1'b0) begin $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); n_fail++; end
        n_checks++; if (rx_byte !== 8'h00) begin $display("FAIL reset_rx_byte: got %h expected 00", rx_byte); n_fail++; end
        n_checks++; if (hdr_di !== 8'h00) begin $display("FAIL reset_hdr_di: got %h expected 00", hdr_di); n_fail++; end
        n_checks++; if (hdr_wc !== 16'h0000) begin $display("FAIL reset_hdr_wc: got %h expected 0000", hdr_wc); n_fail++; end
        n_checks++;
        if ({rx_sop, rx_eop, pkt_done, pkt_long, crc_err, lane_err, ovf_err} !== 7'b0) begin
            $display("FAIL reset_flags: got %b expected 0000000",
                     {rx_sop, rx_eop, pkt_done, pkt_long, crc_err, lane_err, ovf_err});
            n_fail++;
        end
    endtask

    task automatic test_short_packet;
        int d0, v0;
        do_reset();
        active_lanes = 2'd0; rx_ready = 1'b1;
        d0 = done_n; v0 = valid_n;
        push(8'h05, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        push(8'h11, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        push(8'h22, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        push(8'h33, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        wait_cycles(6);
        n_checks++; if (done_n - d0 != 1) begin $display("FAIL short_done_count: got %0d expected 1", done_n - d0); n_fail++; end
        n_checks++; if (last_long !== 1'b0) begin $display("FAIL short_pkt_long: got %b expected 0", last_long); n_fail++; end
        n_checks++; if (hdr_di !== 8'h05) begin $display("FAIL short_hdr_di: got %h expected 05", hdr_di); n_fail++; end
        n_checks++; if (hdr_wc !== 16'h0000) begin $display("FAIL short_hdr_wc: got %h expected 0000", hdr_wc); n_fail++; end
        n_checks++; if (valid_n - v0 != 0) begin $display("FAIL short_rx_valid: got %0d valid cycles expected 0", valid_n - v0); n_fail++; end
        n_checks++; if (lane_err !== 1'b0) begin $display("FAIL short_lane_err: got %b expected 0", lane_err); n_fail++; end
    endtask

    // Long packet DI=39 WC=4 payload 01..04 over 2 lanes; CRC of payload is C66E
    task automatic send_long_2lane(input logic [7:0] footer_hi);
        active_lanes = 2'd1; rx_ready = 1'b1;
        push(8'h39, 8'h04, 8'hEE, 8'hEE, 4'b0011);
        push(8'h00, 8'h00, 8'hEE, 8'hEE, 4'b0011);
        push(8'h01, 8'h02, 8'hEE, 8'hEE, 4'b0011);
        push(8'h03, 8'h04, 8'hEE, 8'hEE, 4'b0011);
        push(8'h6E, footer_hi, 8'hEE, 8'hEE, 4'b0011);
        wait_cycles(12);
    endtask

    task automatic test_long_packet;
        int b, d0, sops, eops;
        do_reset();
        b = acc_n; d0 = done_n;
        send_long_2lane(8'hC6);
        n_checks++; if (acc_n - b != 4) begin $display("FAIL long_byte_count: got %0d expected 4", acc_n - b); n_fail++; end
        sops = 0; eops = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (acc_byte[b+i] !== 8'(i + 1)) begin
                $display("FAIL long_byte%0d: got %h expected %h", i, acc_byte[b+i], 8'(i + 1)); n_fail++;
            end
            sops += int'(acc_sop[b+i]); eops += int'(acc_eop[b+i]);
        end
        n_checks++; if (acc_sop[b] !== 1'b1 || sops != 1) begin $display("FAIL long_sop: got first=%b total=%0d expected first=1 total=1", acc_sop[b], sops); n_fail++; end
        n_checks++; if (acc_eop[b+3] !== 1'b1 || eops != 1) begin $display("FAIL long_eop: got last=%b total=%0d expected last=1 total=1", acc_eop[b+3], eops); n_fail++; end
        n_checks++; if (acc_cyc[b+3] - acc_cyc[b] != 3) begin $display("FAIL long_back_to_back: got span %0d expected 3", acc_cyc[b+3] - acc_cyc[b]); n_fail++; end
        n_checks++; if (done_n - d0 != 1) begin $display("FAIL long_done_count: got %0d expected 1", done_n - d0); n_fail++; end
        n_checks++; if (last_long !== 1'b1) begin $display("FAIL long_pkt_long: got %b expected 1", last_long); n_fail++; end
        n_checks++; if (last_crc !== 1'b0) begin $display("FAIL long_crc_err: got %b expected 0", last_crc); n_fail++; end
        n_checks++; if (hdr_di !== 8'h39) begin $display("FAIL long_hdr_di: got %h expected 39", hdr_di); n_fail++; end
        n_checks++; if (hdr_wc !== 16'h0004) begin $display("FAIL long_hdr_wc: got %h expected 0004", hdr_wc); n_fail++; end
    endtask

    task automatic test_crc_error;
        int b, d0;
        do_reset();
        b = acc_n; d0 = done_n;
        send_long_2lane(8'h39);
        n_checks++; if (acc_n - b != 4) begin $display("FAIL crcbad_byte_count: got %0d expected 4", acc_n - b); n_fail++; end
        n_checks++; if (acc_byte[b+3] !== 8'h04) begin $display("FAIL crcbad_last_byte: got %h expected 04", acc_byte[b+3]); n_fail++; end
        n_checks++; if (done_n - d0 != 1) begin $display("FAIL crcbad_done_count: got %0d expected 1", done_n - d0); n_fail++; end
        n_checks++; if (last_crc !== 1'b1) begin $display("FAIL crcbad_crc_err: got %b expected 1", last_crc); n_fail++; end
        n_checks++; if (last_long !== 1'b1) begin $display("FAIL crcbad_pkt_long: got %b expected 1", last_long); n_fail++; end
    endtask

    // Header plus six 4-byte payload groups with no consumer: the FIFO fills
    // after the fourth payload group, the last two groups are dropped whole.
    task automatic test_overflow;
        int b, v0, eops;
        logic [7:0] v;
        do_reset();
        active_lanes = 2'd3; rx_ready = 1'b0;
        b = acc_n; v0 = valid_n;
        push(8'h39, 8'h20, 8'h00, 8'h00, 4'b1111);
        for (int g = 0; g < 6; g++) begin
            v = 8'(4 * g + 1);
            push(v, v + 8'd1, v + 8'd2, v + 8'd3, 4'b1111);
        end
        wait_cycles(13);
        n_checks++; if (ovf_err !== 1'b1) begin $display("FAIL ovf_flag: got %b expected 1", ovf_err); n_fail++; end
        n_checks++; if (valid_n - v0 != 0) begin $display("FAIL ovf_no_valid_while_stalled: got %0d expected 0", valid_n - v0); n_fail++; end
        rx_ready = 1'b1;
        wait_cycles(25);
        n_checks++; if (acc_n - b != 16) begin $display("FAIL ovf_drained_count: got %0d expected 16", acc_n - b); n_fail++; end
        eops = 0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (acc_byte[b+i] !== 8'(i + 1)) begin
                $display("FAIL ovf_byte%0d: got %h expected %h", i, acc_byte[b+i], 8'(i + 1)); n_fail++;
            end
            eops += int'(acc_eop[b+i]);
        end
        n_checks++; if (acc_sop[b] !== 1'b1) begin $display("FAIL ovf_sop: got %b expected 1", acc_sop[b]); n_fail++; end
        n_checks++; if (eops != 0) begin $display("FAIL ovf_eop: got %0d expected 0", eops); n_fail++; end
        n_checks++; if (ovf_err !== 1'b1) begin $display("FAIL ovf_sticky: got %b expected 1", ovf_err); n_fail++; end
        rx_ready = 1'b0;
    endtask

    task automatic test_lane_err;
        int d0;
        do_reset();
        active_lanes = 2'd2; rx_ready = 1'b1;
        d0 = done_n;
        push(8'h05, 8'h11, 8'h22, 8'hEE, 4'b0011);
        n_checks++; if (lane_err !== 1'b1) begin $display("FAIL lane_err_set: got %b expected 1", lane_err); n_fail++; end
        wait_cycles(5);
        active_lanes = 2'd0;
        push(8'h33, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        wait_cycles(4);
        n_checks++; if (done_n - d0 != 1) begin $display("FAIL lane_group_written: got %0d packets expected 1", done_n - d0); n_fail++; end
        n_checks++; if (hdr_di !== 8'h05) begin $display("FAIL lane_hdr_di: got %h expected 05", hdr_di); n_fail++; end
        n_checks++; if (lane_err !== 1'b1) begin $display("FAIL lane_err_sticky: got %b expected 1", lane_err); n_fail++; end
        n_checks++; if (ovf_err !== 1'b0) begin $display("FAIL lane_ovf_err: got %b expected 0", ovf_err); n_fail++; end
    endtask

    task automatic test_reset_mid_packet;
        int b, d0, k;
        do_reset();
        active_lanes = 2'd0; rx_ready = 1'b1;
        b = acc_n;
        push(8'h29, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        push(8'h04, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        push(8'h00, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        push(8'h00, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        push(8'h0A, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        push(8'h0B, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        k = 0;
        while (acc_n - b < 2 && k < 20) begin
            wait_cycles(1);
            k++;
        end
        n_checks++; if (acc_n - b < 2) begin $display("FAIL midrst_wait_two_bytes: got %0d expected 2", acc_n - b); n_fail++; end
        d0 = done_n;
        #2 dsi_rst_n = 1'b0;
        #1;
        n_checks++; if (rx_valid !== 1'b0) begin $display("FAIL midrst_rx_valid: got %b expected 0", rx_valid); n_fail++; end
        n_checks++; if (rx_byte !== 8'h00) begin $display("FAIL midrst_rx_byte: got %h expected 00", rx_byte); n_fail++; end
        n_checks++; if (hdr_di !== 8'h00) begin $display("FAIL midrst_hdr_di: got %h expected 00", hdr_di); n_fail++; end
        n_checks++; if (hdr_wc !== 16'h0000) begin $display("FAIL midrst_hdr_wc: got %h expected 0000", hdr_wc); n_fail++; end
        n_checks++;
        if ({rx_sop, rx_eop, pkt_done, pkt_long, crc_err} !== 5'b0) begin
            $display("FAIL midrst_flags: got %b expected 00000", {rx_sop, rx_eop, pkt_done, pkt_long, crc_err}); n_fail++;
        end
        wait_cycles(2);
        dsi_rst_n = 1'b1;
        wait_cycles(1);
        push(8'h15, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        push(8'h11, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        push(8'h22, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        push(8'h33, 8'hEE, 8'hEE, 8'hEE, 4'b0001);
        wait_cycles(6);
        n_checks++; if (done_n - d0 != 1) begin $display("FAIL midrst_after_done: got %0d expected 1", done_n - d0); n_fail++; end
        n_checks++; if (hdr_di !== 8'h15) begin $display("FAIL midrst_after_hdr_di: got %h expected 15", hdr_di); n_fail++; end
        n_checks++; if (last_long !== 1'b0) begin $display("FAIL midrst_after_long: got %b expected 0", last_long); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_short_packet();
        test_long_packet();
        test_crc_error();
        test_overflow();
        test_lane_err();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
